sha256_block_ctrl: RTL and testbench
====================================

# sha256_block_ctrl

Sequencer for one SHA-256 compression pass. It owns the 16-word message buffer filled from the AXI-Lite register slave, expands the message schedule on the fly, and drives the external compression datapath through its 64 rounds. It also produces the done pulse and the sticky pending bit that feeds the interrupt slave. It sits between the `S00_AXI` register file and the round datapath inside the accelerator IP.

## Interface
Parameters:
- `ROUNDS`, 64: compression rounds per block. Fixed by the standard; exposed only for the bench.

Ports:
- `ACLK` in 1: clock.
- `ARESET` in 1: asynchronous, active-high reset.
- `cfg_start` in 1: one-cycle start pulse from the CTRL register write.
- `cfg_init` in 1: sampled with `cfg_start`. 1 loads the IV into H; 0 chains from the current H.
- `msg_wr_en` in 1: message word write strobe.
- `msg_wr_addr` in 4: word index 0..15.
- `msg_wr_data` in 32: message word, big-endian word order.
- `msg_wr_drop` out 1: pulses when a write is ignored because the block is busy.
- `busy` out 1: high from the INIT state through the DONE state.
- `done` out 1: one-cycle pulse in the DONE state.
- `irq_en` in 1: interrupt enable bit from the interrupt slave.
- `irq_ack` in 1: ack pulse; clears the pending bit.
- `irq_pend` out 1: sticky pending bit.
- `irq` out 1: `irq_pend & irq_en`.
- `core_load_iv` out 1: datapath loads H0..H7 from the IV.
- `core_init_state` out 1: datapath copies H into working registers a..h.
- `core_round_en` out 1: datapath executes one round this cycle.
- `core_round_idx` out 6: round t.
- `core_kt` out 32: K[t].
- `core_wt` out 32: W[t].
- `core_fold` out 1: datapath performs H += a..h.

## Operation
- FSM states: IDLE, INIT, ROUND, FOLD, DONE.
- IDLE:
  - On `cfg_start`, latch `cfg_init` and go to INIT.
  - Message writes are accepted only in IDLE.
- INIT (1 cycle):
  - `core_init_state` = 1.
  - `core_load_iv` = latched init flag. The datapath must load the IV and copy it into a..h in the same cycle.
  - Clear t to 0 and go to ROUND.
- ROUND (`ROUNDS` cycles):
  - `core_round_en` = 1 and `core_round_idx` = t.
  - For t < 16: W[t] = buf[t].
  - For t ≥ 16: W[t] = σ1(buf[(t-2)%16]) + buf[(t-7)%16] + σ0(buf[(t-15)%16]) + buf[t%16], modulo 2^32.
  - For t ≥ 16, W[t] is written back to buf[t%16] at the clock edge.
  - When t = 63, go to FOLD. Otherwise increment t.
- FOLD (1 cycle): `core_fold` = 1, then go to DONE.
- DONE (1 cycle): `done` = 1, set `irq_pend`, then go to IDLE.
- Buffer contents are undefined after a block completes. Software rewrites all 16 words before the next start.
- Sigma functions:
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - All adds are 32-bit with the carry discarded.
- Boundary conditions:
  - `cfg_start` while busy: ignored, no queueing.
  - `msg_wr_en` while busy: buffer unchanged, `msg_wr_drop` pulses the next cycle.
  - `irq_ack` in the same cycle as the DONE set: set wins, so `irq_pend` stays 1.
  - `irq_ack` with nothing pending: no effect.
  - `irq_en` low: `irq_pend` still sets; `irq` rises as soon as `irq_en` goes high.

## Timing
- Outputs are registered except `core_kt`, `core_wt` and `irq`, which are combinational from registered state.
- Start sampled at edge N:
  - INIT in cycle N+1.
  - ROUND in cycles N+2..N+65.
  - FOLD in cycle N+66.
  - DONE, `done` pulse, in cycle N+67.
  - `irq_pend` is 1 from N+68.
- A new start is accepted at the earliest in cycle N+68.
- Message write latency: 1 cycle. A word written at edge M is visible to a start sampled at edge M+1.
- Reset (asynchronous, any state):
  - FSM goes to IDLE and t goes to 0.
  - All outputs drop to 0, including `irq_pend` and `irq`.
  - The message buffer is not reset and its contents are undefined.
  - After reset mid-round, the datapath state is stale; the next start must use `cfg_init` = 1.

## Structure
- `sha256_pkg` holds:
  - the state enum type;
  - the K[0..63] constant array;
  - the IV constants;
  - the `sigma0`/`sigma1` functions;
  - `WORD_W` = 32.
- Sub-module `sha256_msg_sched` contains the 16×32 circular buffer, the write port and the W[t] expansion/write-back. Its inputs are t and a round-enable from the FSM.
- The FSM, counter, K lookup and interrupt pending logic stay in `sha256_block_ctrl`.

## Test plan
- Load the padded "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), `cfg_init`=1, start:
  - t=0: `core_wt`=0x61626380, `core_kt`=0x428a2f98.
  - t=16: `core_wt`=0x61626380.
  - t=17: `core_wt`=0x000F0000.
  - t=63: `core_kt`=0xc67178f2.
  - `done` exactly 67 cycles after the start edge.
- Second start with `cfg_init`=0: `core_load_iv` stays 0 in INIT; `core_init_state` is 1 for exactly one cycle.
- Pulse `cfg_start` and `msg_wr_en` (addr 3, 0xDEADBEEF) at t=10:
  - no restart;
  - `msg_wr_drop`=1 one cycle later;
  - `done` timing unchanged.
- Interrupt with `irq_en`=0 at `done`: `irq_pend`=1, `irq`=0. Set `irq_en`=1: `irq`=1. Pulse `irq_ack`: `irq_pend`=0 and `irq`=0 next cycle.
- `irq_ack` coincident with DONE: `irq_pend`=1 afterwards.
- Assert `ARESET` at t=30:
  - outputs 0 immediately, without waiting for a clock edge;
  - FSM in IDLE;
  - a later "abc" reload and start reproduces the first test's values.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and helpers for the SHA-256 block sequencer.
//   WORD_W      - datapath word width (32)
//   state_e     - sequencer state encoding
//   K           - round constants K[0..63]
//   IV          - initial hash value H0..H7
//   sigma0/1    - message schedule small-sigma functions
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [WORD_W-1:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [WORD_W-1:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1 = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_block_ctrl_if.sv
// sha256_block_ctrl_if: register-file side of the block sequencer.
//   master (register file): cfg_start, cfg_init, msg_wr_en/addr/data, irq_en, irq_ack
//   slave  (sequencer)    : msg_wr_drop, busy, done, irq_pend, irq
interface sha256_block_ctrl_if
  import sha256_pkg::*;
();

  logic              cfg_start;
  logic              cfg_init;
  logic              msg_wr_en;
  logic [3:0]        msg_wr_addr;
  logic [WORD_W-1:0] msg_wr_data;
  logic              msg_wr_drop;
  logic              busy;
  logic              done;
  logic              irq_en;
  logic              irq_ack;
  logic              irq_pend;
  logic              irq;

  modport master (
    output cfg_start, cfg_init, msg_wr_en, msg_wr_addr, msg_wr_data, irq_en, irq_ack,
    input  msg_wr_drop, busy, done, irq_pend, irq
  );

  modport slave (
    input  cfg_start, cfg_init, msg_wr_en, msg_wr_addr, msg_wr_data, irq_en, irq_ack,
    output msg_wr_drop, busy, done, irq_pend, irq
  );

endinterface

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word circular message buffer with on-the-fly W[t] expansion.
//   clk        - clock (buffer has no reset; contents undefined until written)
//   i_wr_en    - write strobe, already qualified by the sequencer (idle only)
//   i_wr_addr  - word index 0..15
//   i_wr_data  - message word
//   i_round_en - a round executes this cycle
//   i_t        - round index t
//   o_wt       - W[t] for the current t
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [3:0]        i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_round_en,
  input  logic [5:0]        i_t,
  output logic [WORD_W-1:0] o_wt
);

  logic [WORD_W-1:0] r_buf [0:15];
  logic [3:0]        w_idx;
  logic [WORD_W-1:0] w_expand;

  // Slot t%16 still holds W[t-16]; the other taps are read modulo 16.
  // (t-15)%16 is the same slot as (t+1)%16.
  assign w_idx    = i_t[3:0];
  assign w_expand = sigma1(r_buf[w_idx - 4'd2]) + r_buf[w_idx - 4'd7]
                  + sigma0(r_buf[w_idx - 4'd15]) + r_buf[w_idx];
  assign o_wt     = (i_t < 6'd16) ? r_buf[w_idx] : w_expand;

  // Buffer update: host writes while idle, W[t] write-back during rounds 16..63
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_buf[i_wr_addr] <= i_wr_data;
    end else if (i_round_en && (i_t >= 6'd16)) begin
      r_buf[w_idx] <= w_expand;
    end
  end

endmodule

// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl: sequencer for one SHA-256 compression pass.
//   ACLK, ARESET     - clock, asynchronous active-high reset
//   bus (slave)      - start/init, message write port, drop/busy/done, interrupt
//   core_load_iv     - datapath loads H from the IV (INIT, when init requested)
//   core_init_state  - datapath copies H into a..h (INIT)
//   core_round_en    - one round this cycle; core_round_idx = t
//   core_kt, core_wt - K[t], W[t] (zero outside rounds)
//   core_fold        - datapath performs H += a..h
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic                ACLK,
  input  logic                ARESET,
  sha256_block_ctrl_if.slave  bus,
  output logic                core_load_iv,
  output logic                core_init_state,
  output logic                core_round_en,
  output logic [5:0]          core_round_idx,
  output logic [WORD_W-1:0]   core_kt,
  output logic [WORD_W-1:0]   core_wt,
  output logic                core_fold
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_INIT  = ST_INIT;
  localparam logic [2:0] S_ROUND = ST_ROUND;
  localparam logic [2:0] S_FOLD  = ST_FOLD;
  localparam logic [2:0] S_DONE  = ST_DONE;
  localparam logic [5:0] T_LAST  = 6'(ROUNDS - 1);

  logic [2:0]        r_state;
  logic [5:0]        r_t;
  logic              r_busy;
  logic              r_done;
  logic              r_drop;
  logic              r_pend;
  logic              r_load_iv;
  logic              r_init_state;
  logic              r_round_en;
  logic              r_fold;

  logic [2:0]        w_state_nxt;
  logic [5:0]        w_t_nxt;
  logic              w_idle;
  logic              w_start;
  logic              w_msg_wr;
  logic [WORD_W-1:0] w_wt;

  assign w_idle   = (r_state == S_IDLE);
  assign w_start  = w_idle & bus.cfg_start;
  assign w_msg_wr = w_idle & bus.msg_wr_en;

  // Next-state and round-counter logic; t is kept at 0 outside ROUND
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    case (r_state)
      S_IDLE: begin
        if (bus.cfg_start) begin
          w_state_nxt = S_INIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
        w_t_nxt = 6'd0;
      end
      S_INIT: begin
        w_state_nxt = S_ROUND;
        w_t_nxt     = 6'd0;
      end
      S_ROUND: begin
        if (r_t == T_LAST) begin
          w_state_nxt = S_FOLD;
          w_t_nxt     = 6'd0;
        end else begin
          w_state_nxt = S_ROUND;
          w_t_nxt     = r_t + 6'd1;
        end
      end
      S_FOLD: begin
        w_state_nxt = S_DONE;
        w_t_nxt     = 6'd0;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_t_nxt     = 6'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_t_nxt     = 6'd0;
      end
    endcase
  end

  // State, counter and registered outputs (decoded from the next state so they align with it)
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_t          <= 6'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_drop       <= 1'b0;
      r_load_iv    <= 1'b0;
      r_init_state <= 1'b0;
      r_round_en   <= 1'b0;
      r_fold       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_t          <= w_t_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
      r_drop       <= bus.msg_wr_en & ~w_idle;
      // init flag is captured together with the start and is only valid in INIT
      r_load_iv    <= w_start & bus.cfg_init;
      r_init_state <= (w_state_nxt == S_INIT);
      r_round_en   <= (w_state_nxt == S_ROUND);
      r_fold       <= (w_state_nxt == S_FOLD);
    end
  end

  // Sticky interrupt pending: set in DONE wins over a coincident ack
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_pend <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_pend <= 1'b1;
    end else if (bus.irq_ack) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= r_pend;
    end
  end

  sha256_msg_sched u_sched (
    .clk        (ACLK),
    .i_wr_en    (w_msg_wr),
    .i_wr_addr  (bus.msg_wr_addr),
    .i_wr_data  (bus.msg_wr_data),
    .i_round_en (r_round_en),
    .i_t        (r_t),
    .o_wt       (w_wt)
  );

  // K/W are gated by the registered round enable so they read zero outside rounds and in reset
  assign core_kt         = r_round_en ? K[r_t] : {WORD_W{1'b0}};
  assign core_wt         = r_round_en ? w_wt   : {WORD_W{1'b0}};
  assign core_round_idx  = r_t;
  assign core_load_iv    = r_load_iv;
  assign core_init_state = r_init_state;
  assign core_round_en   = r_round_en;
  assign core_fold       = r_fold;

  assign bus.msg_wr_drop = r_drop;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.irq_pend    = r_pend;
  assign bus.irq         = r_pend & bus.irq_en;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb_sha256_block_ctrl: self-checking bench for sha256_block_ctrl.
// A phase-based reference model (full 64-entry schedule array, cycle phase since start)
// is compared against every output on every falling edge; literal checks pin the model.
module tb_sha256_block_ctrl;

  localparam int R = 64;

  typedef logic [31:0] warr_t [64];
  typedef logic [31:0] marr_t [16];

  localparam logic [31:0] KREF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        core_load_iv, core_init_state, core_round_en, core_fold;
  logic [5:0]  core_round_idx;
  logic [31:0] core_kt, core_wt;

  sha256_block_ctrl_if bus();

  sha256_block_ctrl #(.ROUNDS(R)) dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .bus             (bus),
    .core_load_iv    (core_load_iv),
    .core_init_state (core_init_state),
    .core_round_en   (core_round_en),
    .core_round_idx  (core_round_idx),
    .core_kt         (core_kt),
    .core_wt         (core_wt),
    .core_fold       (core_fold)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Standard full-array message schedule expansion
  function automatic warr_t expand(input marr_t m);
    warr_t w;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = m[i];
      else        w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
    end
    return w;
  endfunction

  // Reference model: m_p = -1 idle, 0 INIT, 1..R round t=m_p-1, R+1 FOLD, R+2 DONE
  int    m_p = -1;
  logic  m_pend = 1'b0;
  logic  m_drop = 1'b0;
  logic  m_init = 1'b0;
  marr_t m_mem;
  warr_t m_w;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_p    <= -1;
      m_pend <= 1'b0;
      m_drop <= 1'b0;
      m_init <= 1'b0;
    end else begin
      m_drop <= bus.msg_wr_en && (m_p >= 0);
      if (m_p == -1 && bus.msg_wr_en) m_mem[bus.msg_wr_addr] <= bus.msg_wr_data;
      if (m_p == R + 2) begin
        m_p    <= -1;
        m_pend <= 1'b1;
      end else begin
        if (bus.irq_ack) m_pend <= 1'b0;
        if (m_p >= 0) begin
          m_p <= m_p + 1;
        end else if (bus.cfg_start) begin
          m_p    <= 0;
          m_w    <= expand(m_mem);
          m_init <= bus.cfg_init;
        end
      end
    end
  end

  // Compare process: every output against the model on every falling edge
  logic e_rnd;
  int   e_t;
  always @(negedge ACLK) begin
    e_rnd = (m_p >= 1) && (m_p <= R);
    e_t   = e_rnd ? (m_p - 1) : 0;
    chkb("busy",        bus.busy,        m_p >= 0);
    chkb("done",        bus.done,        m_p == R + 2);
    chkb("init_state",  core_init_state, m_p == 0);
    chkb("load_iv",     core_load_iv,    (m_p == 0) && m_init);
    chkb("round_en",    core_round_en,   e_rnd);
    chkb("fold",        core_fold,       m_p == R + 1);
    chk ("round_idx",   32'(core_round_idx), 32'(e_t));
    chk ("kt",          core_kt,         e_rnd ? KREF[e_t] : 32'h0);
    chk ("wt",          core_wt,         e_rnd ? m_w[e_t]  : 32'h0);
    chkb("wr_drop",     bus.msg_wr_drop, m_drop);
    chkb("irq_pend",    bus.irq_pend,    m_pend);
    chkb("irq",         bus.irq,         m_pend & bus.irq_en);
  end

  task automatic load_block(input marr_t m);
    for (int i = 0; i < 16; i++) begin
      @(negedge ACLK); #1;
      bus.msg_wr_en   = 1'b1;
      bus.msg_wr_addr = i[3:0];
      bus.msg_wr_data = m[i];
    end
    @(negedge ACLK); #1;
    bus.msg_wr_en = 1'b0;
  endtask

  // Run one block. Phase j is observed at the j-th falling edge after the start edge.
  task automatic run_block(input logic ini, input bit lit, input int inj_j,
                           input int rst_j, input int ack_j, input bit rnd);
    int done_j;
    int init_cnt;
    done_j   = -1;
    init_cnt = 0;
    @(negedge ACLK); #1;
    bus.cfg_start = 1'b1;
    bus.cfg_init  = ini;
    @(negedge ACLK);
    for (int j = 0; j < 70; j++) begin
      if (j > 0) @(negedge ACLK);
      if (core_init_state) init_cnt++;
      if (bus.done && done_j < 0) done_j = j;
      if (j == 0) chkb("init_load_iv", core_load_iv, ini);
      if (lit && j == 1)  begin chk("t0_wt", core_wt, 32'h61626380); chk("t0_kt", core_kt, 32'h428a2f98); end
      if (lit && j == 17) chk("t16_wt", core_wt, 32'h61626380);
      if (lit && j == 18) chk("t17_wt", core_wt, 32'h000F0000);
      if (lit && j == 64) chk("t63_kt", core_kt, 32'hc67178f2);
      if (inj_j >= 0 && j == inj_j + 1) chkb("drop_pulse", bus.msg_wr_drop, 1'b1);
      if (ack_j >= 0 && j == ack_j + 1) chkb("ack_at_done_pend", bus.irq_pend, 1'b1);
      #1;
      bus.cfg_start = 1'b0;
      bus.msg_wr_en = 1'b0;
      bus.irq_ack   = 1'b0;
      if (j == inj_j) begin
        bus.cfg_start   = 1'b1;
        bus.msg_wr_en   = 1'b1;
        bus.msg_wr_addr = 4'd3;
        bus.msg_wr_data = 32'hDEADBEEF;
      end
      if (j == ack_j) bus.irq_ack = 1'b1;
      if (rnd && j >= 1 && j <= R) begin
        if ($urandom_range(7, 0) == 0) bus.irq_en = ~bus.irq_en;
        if ($urandom_range(5, 0) == 0) bus.irq_ack = 1'b1;
        if ($urandom_range(4, 0) == 0) begin
          bus.msg_wr_en   = 1'b1;
          bus.msg_wr_addr = 4'($urandom_range(15, 0));
          bus.msg_wr_data = $urandom;
        end
        if ($urandom_range(9, 0) == 0) begin
          bus.cfg_start = 1'b1;
          bus.cfg_init  = 1'($urandom_range(1, 0));
        end
      end
      if (j == rst_j) begin
        ARESET = 1'b1;
        #1;
        chk("rst_ctrl_bits", {20'h0, bus.busy, bus.done, core_init_state, core_load_iv, core_round_en,
                              core_fold, bus.msg_wr_drop, bus.irq_pend, bus.irq, 3'b000}, 32'h0);
        chk("rst_idx", 32'(core_round_idx), 32'h0);
        chk("rst_kt",  core_kt, 32'h0);
        chk("rst_wt",  core_wt, 32'h0);
        @(negedge ACLK);
        chkb("rst_idle", bus.busy, 1'b0);
        #1;
        ARESET = 1'b0;
        return;
      end
    end
    chk("done_cycle", 32'(done_j), 32'd66);
    chk("init_once",  32'(init_cnt), 32'd1);
  endtask

  marr_t abc;
  marr_t rm;

  initial begin
    bus.cfg_start   = 1'b0;
    bus.cfg_init    = 1'b0;
    bus.msg_wr_en   = 1'b0;
    bus.msg_wr_addr = 4'd0;
    bus.msg_wr_data = 32'h0;
    bus.irq_en      = 1'b0;
    bus.irq_ack     = 1'b0;
    for (int i = 0; i < 16; i++) abc[i] = 32'h0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    #1 ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chkb("reset_busy", bus.busy, 1'b0);
    chkb("reset_pend", bus.irq_pend, 1'b0);

    // ack with nothing pending
    #1 bus.irq_ack = 1'b1;
    @(negedge ACLK);
    chkb("ack_idle_pend", bus.irq_pend, 1'b0);
    #1 bus.irq_ack = 1'b0;

    // "abc" block, IV load, interrupt masked
    load_block(abc);
    run_block(1'b1, 1'b1, -1, -1, -1, 1'b0);
    chkb("masked_pend", bus.irq_pend, 1'b1);
    chkb("masked_irq",  bus.irq,      1'b0);
    bus.irq_en = 1'b1;
    #1 chkb("unmasked_irq", bus.irq, 1'b1);
    @(negedge ACLK); #1 bus.irq_ack = 1'b1;
    @(negedge ACLK);
    chkb("acked_pend", bus.irq_pend, 1'b0);
    chkb("acked_irq",  bus.irq,      1'b0);
    #1 bus.irq_ack = 1'b0;

    // chained block with ack coincident with DONE
    load_block(abc);
    run_block(1'b0, 1'b1, -1, -1, 66, 1'b0);

    // start + write while busy at t=10
    load_block(abc);
    run_block(1'b1, 1'b1, 11, -1, -1, 1'b0);

    // asynchronous reset at t=30, then a clean rerun
    load_block(abc);
    run_block(1'b1, 1'b0, -1, 31, -1, 1'b0);
    load_block(abc);
    run_block(1'b1, 1'b1, -1, -1, -1, 1'b0);

    // randomized blocks
    repeat (4) begin
      for (int i = 0; i < 16; i++) rm[i] = $urandom;
      load_block(rm);
      run_block(1'($urandom_range(1, 0)), 1'b0, -1, -1, -1, 1'b1);
    end

    @(negedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
